// File: rtl/count_packet_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : freq_meter_pkg
//  Description : Shared types and constants for the frequency-meter result
//                path: packet framing constants, UART byte FSM state type and
//                the packet byte selector (header / count hi / count lo /
//                checksum).
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;
  localparam int         PKT_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Byte idx of the packet carrying `value`. The checksum is derived straight
  // from the value, so it costs no extra pipeline stage.
  function automatic logic [7:0] pkt_byte(input logic [15:0] value,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = PKT_HEADER;
      2'd1:    b = value[15:8];
      2'd2:    b = value[7:0];
      default: b = PKT_HEADER ^ value[15:8] ^ value[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/count_packet_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : count_packet_tx_if
//  Description : Bundle between the edge counter / host pin side and the
//                count packet transmitter.
//                  send_packet : one-cycle request strobe
//                  counter     : 16-bit count sampled with the strobe
//                  tx          : UART 8N1 line, idle high
//                  busy        : packet being shifted out
//                  dropped     : one-cycle pulse when a pending value is lost
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_packet_tx_if;
  logic        send_packet;
  logic [15:0] counter;
  logic        tx;
  logic        busy;
  logic        dropped;

  // Master: the side that issues requests and watches the line.
  modport master (
    output send_packet,
    output counter,
    input  tx,
    input  busy,
    input  dropped
  );

  // Slave: the transmitter itself.
  modport slave (
    input  send_packet,
    input  counter,
    output tx,
    output busy,
    output dropped
  );
endinterface
`default_nettype wire

// File: rtl/count_packet_tx_uart_tx_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : UART 8N1 byte serialiser. Owns the baud and bit counters.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                i_start  - load i_data and begin a byte (accepted in IDLE
//                           or in the last cycle of the stop bit)
//                i_data   - byte to send, LSB first
//                o_tx     - registered serial line, idle high
//                o_done   - high in the last cycle of the stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import freq_meter_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  wire       clk,
  input  wire       rst,
  input  wire       i_start,
  input  wire [7:0] i_data,
  output logic      o_tx,
  output logic      o_done
);

  localparam int             BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);
  assign o_done    = (r_state == STOP) && w_bit_end;
  assign o_tx      = r_tx;

  // The line value for the next bit is loaded on the same edge that ends the
  // current bit, so o_tx changes exactly on bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (i_start) begin
            r_shift <= i_data;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            // A start in the final stop cycle chains the next byte with no
            // idle bit in between.
            if (i_start) begin
              r_shift <= i_data;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_packet_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : count_packet_tx
//  Description : Frequency-meter result transmitter. Snapshots the 16-bit
//                count on a send strobe and emits A5 / hi / lo / checksum as
//                four back-to-back UART 8N1 bytes. One result can wait in a
//                pending slot while a packet is in flight; overwriting it
//                pulses dropped.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - count_packet_tx_if.slave
//                       (send_packet, counter in; tx, busy, dropped out)
//  Revision    : 1.0 - initial release
// ============================================================================
module count_packet_tx
  import freq_meter_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  wire               clk,
  input  wire               rst,
  count_packet_tx_if.slave  bus
);

  logic [15:0] r_snap;
  logic [15:0] r_pend_val;
  logic        r_pend;
  logic        r_busy;
  logic        r_dropped;
  logic [1:0]  r_byte_idx;

  logic        w_done;
  logic        w_tx;
  logic        w_accept;
  logic        w_frame_end;
  logic        w_chain;
  logic        w_start;
  logic [1:0]  w_next_idx;
  logic [7:0]  w_byte;

  assign w_next_idx  = r_byte_idx + 2'd1;
  assign w_accept    = !r_busy && bus.send_packet;
  assign w_frame_end = w_done && (r_byte_idx == 2'(PKT_BYTES - 1));
  // A new frame follows directly when something is waiting or a strobe lands
  // exactly in the final stop cycle.
  assign w_chain     = w_frame_end && (r_pend || bus.send_packet);
  assign w_start     = w_accept || w_chain || (w_done && !w_frame_end);

  // Every frame opens with the fixed header, so the byte issued at frame
  // start never depends on the snapshot being loaded on that same edge.
  assign w_byte = (w_accept || w_chain) ? PKT_HEADER
                                        : pkt_byte(r_snap, w_next_idx);

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx_byte (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_data  (w_byte),
    .o_tx    (w_tx),
    .o_done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap     <= 16'd0;
      r_pend_val <= 16'd0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
      r_byte_idx <= 2'd0;
    end else begin
      // Any strobe while busy lands in the pending slot (or, at frame end,
      // directly in the next frame); an already-full slot means a loss.
      r_dropped <= r_busy && bus.send_packet && r_pend;

      if (w_accept) begin
        r_snap     <= bus.counter;
        r_busy     <= 1'b1;
        r_byte_idx <= 2'd0;
      end else if (w_frame_end) begin
        r_byte_idx <= 2'd0;
        if (bus.send_packet) begin
          r_snap <= bus.counter;
          r_pend <= 1'b0;
        end else if (r_pend) begin
          r_snap <= r_pend_val;
          r_pend <= 1'b0;
        end else begin
          r_busy <= 1'b0;
        end
      end else begin
        if (w_done) begin
          r_byte_idx <= w_next_idx;
        end
        if (r_busy && bus.send_packet) begin
          r_pend     <= 1'b1;
          r_pend_val <= bus.counter;
        end
      end
    end
  end

  assign bus.tx      = w_tx;
  assign bus.busy    = r_busy;
  assign bus.dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_count_packet_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_count_packet_tx
//  Description : Self-checking bench for count_packet_tx. A cycle-level
//                reference model of the frame schedule pushes expected bytes
//                (value + start cycle) into a queue; an independent UART
//                decoder on the line pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_packet_tx;

  localparam int D     = 4;
  localparam int BYTE  = 10 * D;
  localparam int FRAME = 40 * D;

  typedef struct {
    logic [7:0] val;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_packet_tx_if bus ();

  count_packet_tx #(
    .CLK_DIV (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        q[$];
  int          n_chk     = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  int          epoch     = 0;
  int          drop_seen = 0;
  int          busy_cnt  = 0;

  // Reference model state: is a frame scheduled, when its last cycle is,
  // and the one-deep pending slot.
  bit          m_busy = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_drop = 1'b0;
  int          m_end  = 0;
  logic [15:0] m_pv   = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input int fs);
    logic [7:0] b [4];
    b[0] = 8'hA5;
    b[1] = v[15:8];
    b[2] = v[7:0];
    b[3] = 8'hA5 ^ v[15:8] ^ v[7:0];
    for (int j = 0; j < 4; j++) begin
      exp_t e;
      e.val = b[j];
      e.t   = fs + j * BYTE;
      q.push_back(e);
    end
  endtask

  // Strobe s with value v presented in cycle t.
  task automatic model(input bit s, input logic [15:0] v, input int t);
    m_drop = 1'b0;
    if (!m_busy) begin
      if (s) begin
        m_busy = 1'b1;
        m_end  = t + FRAME;
        push_frame(v, t + 1);
      end
    end else if (t == m_end) begin
      if (s) begin
        m_drop = m_pend;
        m_pend = 1'b0;
        m_end  = t + FRAME;
        push_frame(v, t + 1);
      end else if (m_pend) begin
        m_pend = 1'b0;
        m_end  = t + FRAME;
        push_frame(m_pv, t + 1);
      end else begin
        m_busy = 1'b0;
      end
    end else if (s) begin
      m_drop = m_pend;
      m_pend = 1'b1;
      m_pv   = v;
    end
  endtask

  task automatic step(input bit s, input logic [15:0] v);
    @(negedge clk);
    check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
    check("dropped", {31'd0, bus.dropped}, {31'd0, m_drop});
    if (bus.dropped === 1'b1) drop_seen++;
    if (bus.busy === 1'b1) busy_cnt++;
    bus.send_packet = s;
    bus.counter     = v;
    model(s, v, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.send_packet = 1'b0;
    epoch++;
    q.delete();
    m_busy = 1'b0;
    m_pend = 1'b0;
    m_drop = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_dropped", {31'd0, bus.dropped}, 32'd0);
    rst = 1'b0;
    model(1'b0, 16'd0, cyc);
  endtask

  // Line decoder: finds a start bit, samples mid-bit, compares with queue.
  initial begin : monitor
    forever begin
      int         ep;
      int         ts;
      logic       sb;
      logic       stp;
      logic [7:0] d;
      @(negedge clk);
      if (rst !== 1'b0 || bus.tx !== 1'b0) continue;
      ep = epoch;
      ts = cyc;
      repeat (D / 2) @(negedge clk);
      sb = bus.tx;
      for (int i = 0; i < 8; i++) begin
        repeat (D) @(negedge clk);
        d[i] = bus.tx;
      end
      repeat (D) @(negedge clk);
      stp = bus.tx;
      if (ep != epoch) continue;
      check("start_bit", {31'd0, sb}, 32'd0);
      check("stop_bit", {31'd0, stp}, 32'd1);
      if (q.size() == 0) begin
        check("unexpected_byte", {24'd0, d}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("byte_val", {24'd0, d}, {24'd0, e.val});
        check("byte_time", ts, e.t);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int guard;
    rst             = 1'b1;
    bus.send_packet = 1'b0;
    bus.counter     = 16'd0;
    do_reset();

    // Single packet, busy length and first start bit.
    busy_cnt = 0;
    step(1'b1, 16'h1234);
    step(1'b0, 16'($urandom));
    check("tx_start", {31'd0, bus.tx}, 32'd0);
    idle(FRAME + 40);
    check("busy_len", busy_cnt, FRAME);

    // Two strobes 20 cycles apart: back-to-back, no drops.
    drop_seen = 0;
    step(1'b1, 16'h0000);
    idle(19);
    step(1'b1, 16'hFFFF);
    idle(2 * FRAME + 20);
    check("drops_t2", drop_seen, 0);

    // Three strobes during one frame: two drops, last value wins.
    drop_seen = 0;
    step(1'b1, 16'h5555);
    idle(9);
    step(1'b1, 16'h0001);
    idle(19);
    step(1'b1, 16'h0002);
    idle(19);
    step(1'b1, 16'h0003);
    idle(2 * FRAME + 20);
    check("drops_t3", drop_seen, 2);

    // Strobe in the final stop-bit cycle: busy must stay high throughout.
    busy_cnt = 0;
    step(1'b1, 16'h7777);
    idle(FRAME - 1);
    step(1'b1, 16'h00AA);
    idle(FRAME + 20);
    check("busy_len_chain", busy_cnt, 2 * FRAME);

    // Reset in the middle of a frame with a pending value stored.
    step(1'b1, 16'hBEEF);
    idle(19);
    step(1'b1, 16'hCAFE);
    idle(29);
    do_reset();
    idle(FRAME);
    step(1'b1, 16'h0F0F);
    idle(FRAME + 20);

    // Counter moving every cycle during a frame.
    step(1'b1, 16'h3C5A);
    idle(FRAME + 20);

    // Random traffic: sparse, then dense enough to force overwrites.
    for (int i = 0; i < 3000; i++) begin
      bit s;
      s = ($urandom_range(0, 999) < ((i < 1500) ? 10 : 50));
      step(s, 16'($urandom));
    end

    guard = 0;
    while ((m_busy || q.size() != 0) && guard < 3 * FRAME) begin
      idle(1);
      guard++;
    end
    idle(10);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_packet_tx.md
# count_packet_tx

Serialising transmitter for the frequency-meter result path. It accepts the 16-bit edge count and one-cycle `send_packet` strobe produced by the edge-counter block, and snapshots the count. It then emits a 4-byte framed packet on a UART 8N1 line toward the host. It sits between the counter and the board's serial pin and buffers one pending result while a packet is in flight.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, synchronous, active-high.
- `send_packet  in  1`: one-cycle request strobe; sample `counter` in the same cycle.
- `counter  in  16`: count value to transmit.
- `tx  out  1`: UART line; idle high.
- `busy  out  1`: high while a packet is being shifted out.
- `dropped  out  1`: one-cycle pulse when a pending result is overwritten.

## Operation
- Packet byte order:
  - `8'hA5` header
  - `counter[15:8]`
  - `counter[7:0]`
  - checksum = `A5 ^ hi ^ lo`
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly `CLK_DIV` cycles.
- FSM states and transitions:
  - IDLE → START on accepted request.
  - START → DATA after `CLK_DIV` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if byte index < 3, otherwise frame end.
- Counters:
  - baud counter 0..`CLK_DIV`-1, wraps to 0 at each bit boundary.
  - bit index 0..7.
  - byte index 0..3, cleared at frame start.
- Snapshot: `counter` is latched at request acceptance; later changes on `counter` never alter a packet in flight.
- Pending slot (one deep):
  - `send_packet` while `busy` stores the value and sets the pending flag.
  - If the pending flag is already set, the newer value overwrites the stored one and `dropped` pulses in the next cycle.
- Frame end:
  - if pending is set, the next frame starts in the next cycle with no idle gap, and pending is cleared;
  - otherwise the FSM goes to IDLE.
- Simultaneous events:
  - `send_packet` in the last cycle of the final stop bit, with no pending value: the strobe value is accepted directly as the next frame; `busy` stays high.
  - `send_packet` in that same cycle with pending set: the strobe overwrites pending, `dropped` pulses, the new value is sent next, and the old pending value is lost.
- Reset: `tx`=1, `busy`=0, `dropped`=0; pending flag, snapshot and all counters are cleared. A reset mid-frame aborts the frame; `tx` is high in the cycle after reset is sampled.

## Timing
- All outputs are registered.
- `send_packet` sampled high in IDLE at cycle N: `busy`=1 and `tx`=0 (start bit) from cycle N+1.
- Frame length: 40·`CLK_DIV` cycles.
- `busy` falls in the cycle after the last stop-bit cycle when nothing is pending.
- Back-to-back frames: the second start bit begins exactly 40·`CLK_DIV` cycles after the first.
- `dropped`: width 1 cycle, asserted at cycle M+1 for an overwrite sampled at M.
- Throughput: one packet per 40·`CLK_DIV` cycles. The upstream send period (counter cyclic send of 100 cycles) is slower than the frame only when `CLK_DIV` is small, so drops are expected and counted, not errors.

## Structure
- Shared package `freq_meter_pkg` holds:
  - `PKT_HEADER` = `8'hA5`
  - `PKT_BYTES` = 4
  - `tx_state_t` enum {IDLE, START, DATA, STOP}
- Natural sub-module: `uart_tx_byte` (`clk`, `rst`, `start`, `data[7:0]`, `tx`, `done`), parameterised by `CLK_DIV`. It owns the baud and bit counters.
- The top level owns the byte mux, checksum, snapshot, pending slot and `dropped` logic.
- Checksum is combinational from the snapshot; no extra latency.

## Test plan
- `CLK_DIV`=4, `counter`=`16'h1234`, single strobe:
  - line decodes A5, 12, 34, 83;
  - `busy` high for exactly 160 cycles;
  - `tx` low at N+1.
- `counter`=`16'h0000`, then `16'hFFFF`, as two strobes 20 cycles apart:
  - frames A5 00 00 A5 and A5 FF FF A5, back to back with no gap;
  - `dropped` never pulses.
- Three strobes during one frame with values `0x0001`, `0x0002`, `0x0003`:
  - `dropped` pulses twice;
  - the second frame carries `0x0003` (A5 00 03 A6).
- Strobe in the final stop-bit cycle with `counter`=`0x00AA`:
  - next start bit follows immediately;
  - `busy` never drops;
  - frame is A5 00 AA 0F.
- `rst` asserted at cycle 50 of a frame:
  - `tx`=1 and `busy`=0 from the next cycle;
  - pending flag cleared;
  - a strobe afterwards starts a clean frame.
- `counter` changes every cycle during a frame:
  - transmitted bytes match the value sampled at acceptance only.
